// File: rtl/pc_trace_buffer.sv
// Trace capture buffer for fetch-stage (PC, instruction) pairs: arm, trigger,
// post-trigger fill into a circular store, then oldest-first drain over valid/ready.
module pc_trace_buffer #(
    parameter int PC_W      = 64,
    parameter int INSTR_W   = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cap_valid,
    input  logic [PC_W-1:0]        cap_pc,
    input  logic [INSTR_W-1:0]     cap_instr,
    input  logic                   arm,
    input  logic                   trig,
    input  logic                   clear,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [PC_W-1:0]        rd_pc,
    output logic [INSTR_W-1:0]     rd_instr,
    output logic                   rd_last,
    output logic                   wrapped,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + INSTR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    post_cnt_q, post_cnt_d;
    logic          wrapped_q, wrapped_d;
    logic          wr_en;
    logic          rd_fire;
    logic          in_capture;
    logic [EW-1:0] rd_entry;
    logic [EW-1:0] mem_q [DEPTH];

    assign in_capture = (state_q == S_ARMED) || (state_q == S_POST);
    assign rd_fire    = rd_valid && rd_ready;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the values that existed before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (arm) state_d = S_ARMED;
                S_ARMED: begin
                    if (trig) begin
                        if (POST_TRIG == 0) begin
                            // A trigger with nothing captured has nothing to drain.
                            state_d = (count_d != '0) ? S_DONE : S_IDLE;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
                S_POST:  if (cap_valid && post_cnt_q == 8'd1) state_d = S_DONE;
                S_DONE:  if (rd_fire && count_q == CW'(1)) state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        wrapped_d  = wrapped_q;
        wr_en      = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (state_q == S_IDLE) begin
            if (arm) begin
                wr_ptr_d  = '0;
                count_d   = '0;
                wrapped_d = 1'b0;
            end
        end else if (in_capture) begin
            if (cap_valid) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q == CW'(DEPTH)) begin
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            if (state_q == S_ARMED && trig) begin
                post_cnt_d = 8'(POST_TRIG);
            end else if (state_q == S_POST && cap_valid) begin
                post_cnt_d = post_cnt_q - 8'd1;
            end
        end else if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
        // Oldest entry sits count places behind the write pointer (mod DEPTH).
        if (state_d == S_DONE && state_q != S_DONE) begin
            rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            wrapped_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            wrapped_q  <= wrapped_d;
        end
    end

    // NOTE: the storage array has no reset; count gates every read, so stale
    // contents are never visible and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {cap_pc, cap_instr};
        end
    end

    always_comb begin
        rd_valid = (state_q == S_DONE) && (count_q != '0);
        rd_last  = rd_valid && (count_q == CW'(1));
        rd_entry = mem_q[rd_ptr_q];
        rd_pc    = '0;
        rd_instr = '0;
        if (rd_valid) begin
            {rd_pc, rd_instr} = rd_entry;
        end
    end

    assign state   = state_q;
    assign count   = count_q;
    assign wrapped = wrapped_q;

endmodule

// File: doc/pc_trace_buffer.md
Name: pc_trace_buffer

Overview:
- Parametrised, synthesizable capture buffer that records (PC, instruction) pairs from the fetch stage of the pipelined core into a circular store.
- Capture is armed by software or the bench; a trigger freezes the buffer after a programmable number of post-trigger samples.
- The frozen trace is then drained oldest-first over a valid/ready port.
- Replaces ad-hoc per-cycle PC/instruction monitoring with a reusable, depth- and width-configurable block that can sit beside the IF stage in silicon or simulation.

Parameters:
PC_W, 64, width of captured PC
INSTR_W, 32, width of captured instruction
DEPTH, 16, number of entries; power of two, >= 2
POST_TRIG, 8, samples captured after the trigger sample; 0 to 255

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
cap_valid  input  1  a sample is presented this cycle
cap_pc  input  PC_W  PC of the sample
cap_instr  input  INSTR_W  instruction of the sample
arm  input  1  start a new capture (honoured only in IDLE)
trig  input  1  trigger event (honoured only in ARMED)
clear  input  1  synchronous abort to IDLE; has priority over arm, trig and capture
rd_valid  output  1  readout entry available
rd_ready  input  1  consumer accepts the entry
rd_pc  output  PC_W  PC of the current readout entry
rd_instr  output  INSTR_W  instruction of the current readout entry
rd_last  output  1  current entry is the final one
wrapped  output  1  at least one sample was overwritten during this capture
state  output  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
count  output  $clog2(DEPTH)+1  number of valid entries held

Behaviour:
- Reset: asynchronous, active-high; clock and reset are named clk and reset. Reset forces state=IDLE, wr_ptr=0, rd_ptr=0, count=0, post_cnt=0, wrapped=0, rd_valid=0, rd_last=0, rd_pc=0, rd_instr=0. Storage contents need not be cleared.
- Reset asserted mid-capture or mid-readout discards everything; rd_valid drops asynchronously.
- IDLE:
  - arm -> ARMED next cycle; wr_ptr, count and wrapped are cleared.
  - trig and cap_valid are ignored.
- ARMED:
  - Each cycle with cap_valid writes {cap_pc, cap_instr} at wr_ptr; wr_ptr increments mod DEPTH.
  - count increments and saturates at DEPTH. A write while count==DEPTH sets wrapped.
  - trig: the same-cycle sample, if valid, is written and counts as the trigger sample; post_cnt loads POST_TRIG.
  - Next state on trig is POST, or DONE if POST_TRIG==0.
- POST:
  - Each cap_valid writes as in ARMED and decrements post_cnt.
  - The write that brings post_cnt to 0 moves the block to DONE on the next cycle.
  - Cycles without cap_valid do not decrement post_cnt.
  - trig is ignored.
- DONE:
  - On entry, rd_ptr = (wr_ptr - count) mod DEPTH, so readout starts at the oldest entry.
  - rd_valid=1 while count>0.
  - rd_pc and rd_instr are read combinationally from the entry at rd_ptr; rd_last = (count==1).
  - Handshake (rd_valid & rd_ready): rd_ptr increments mod DEPTH and count decrements. The handshake with rd_last moves the block to IDLE next cycle.
  - rd_valid is held with stable data until accepted; cap_valid, arm and trig are ignored.
- Zero-entry DONE (trigger with count==0, POST_TRIG==0, no same-cycle sample): goes directly to IDLE. rd_valid is never asserted.
- clear: any state -> IDLE next cycle; count=0, rd_valid=0. wrapped keeps its value until the next arm.
- Throughput: one capture per cycle; one readout per cycle under continuous rd_ready.
- Pointer arithmetic is $clog2(DEPTH) bits and wraps naturally.

Test Plan:
- Basic capture, DEPTH=16, POST_TRIG=2: arm; 5 samples PC=0x00,0x04,...,0x10 with instr 0x01000093 + i; trig on the 3rd sample -> DONE after the 5th sample. count=5, wrapped=0; readout PCs 0x00..0x10 in order, rd_last on PC 0x10, then state=IDLE.
- Wrap-around, DEPTH=16, POST_TRIG=4: arm; 20 samples PC=4*i; trig on i=15 -> wrapped=1, count=16; readout starts at PC 0x10 and ends at PC 0x4C with rd_last.
- Backpressure: in DONE, hold rd_ready=0 for 3 cycles, then toggle 1/0 -> rd_pc stable while unaccepted; each entry delivered exactly once; no duplicates or skips.
- POST_TRIG=0 edge cases: trig with a valid same-cycle sample (PC 0x20) after 2 earlier samples -> count=3, last entry is PC 0x20. trig with count==0 and no sample -> IDLE with rd_valid never high.
- Gaps and ignored inputs: cap_valid low on alternate cycles during POST -> post_cnt decrements only on valid cycles. trig in IDLE and arm in DONE -> no state change.
- Abort and reset: clear in POST -> IDLE, count=0. Async reset pulse mid-readout (not clock-aligned) -> rd_valid=0 immediately, state=0, count=0; a fresh arm then works normally.
